// File: rtl/border_pkg.sv
// Shared definitions for the border-detection front end.
//   IMG_W / IMG_H / IMG_SIZE : default frame geometry
//   PIX_W                    : grey pixel width
//   pixel_t                  : one grey pixel
//   win_state_t              : window generator control state
package border_pkg;
    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int IMG_SIZE = IMG_W * IMG_H;
    localparam int PIX_W    = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} win_state_t;
endpackage

// File: rtl/pw_line_buffer.sv
// One line of pixel storage for the 3x3 window generator.
// Single address shared by read and write; the read is combinational, so the
// value seen in a write cycle is the previous content (read-before-write).
// Contents are never cleared.
//   clk   : clock
//   we    : write enable
//   addr  : column address
//   wdata : pixel written at addr
//   rdata : pixel currently stored at addr
module pw_line_buffer
    import border_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int DW    = PIX_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream and
// emits one registered window per pixel, in raster order of the centre pixel.
// Build option: PIXEL_WINDOW_REPLICATE_EN replicates the nearest in-image pixel
// for out-of-image taps; otherwise those taps read as zero.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : pixel handshake, in_pixel carries the pixel
//   out_valid/out_ready : window handshake
//   out_win             : 9 taps, k = row*3 + col, k=4 is the centre
//   out_x, out_y        : centre coordinates; out_last marks the final window
module pixel_window_3x3
    import border_pkg::*;
#(
    parameter int WIDTH  = IMG_W,
    parameter int HEIGHT = IMG_H,
    parameter int PW     = PIX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PW-1:0]             in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*PW-1:0]           out_win,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      out_last
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    win_state_t state, state_nxt;

    // ix/iy: position of the next column shifted in (continues past the image
    // during FLUSH). cx/cy: centre of the next window to be loaded.
    logic [XW-1:0] ix, cx;
    logic [YW-1:0] iy, cy;

    logic out_free, in_fire, load, shift;
    logic [PW-1:0] row1_rd, row2_rd;
    logic [2:0][PW-1:0] col_new, hist0, hist1;  // [row], row 0 = top
    logic [8:0][PW-1:0] win;

    always_comb begin
        out_free  = !out_valid || out_ready;
        in_ready  = (state == FILL) || (state == RUN && out_free);
        in_fire   = in_valid && in_ready;
        // In FLUSH stop loading once the final window sits in the output register.
        load      = (state == RUN && in_fire) ||
                    (state == FLUSH && out_free && !(out_valid && out_last));
        shift     = in_fire || load;
        state_nxt = state;
        case (state)
            FILL:    if (in_fire && ix == '0 && iy == YW'(1)) state_nxt = RUN;
            RUN:     if (in_fire && ix == X_MAX && iy == Y_MAX) state_nxt = FLUSH;
            FLUSH:   if (out_valid && out_ready && out_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Newest column: two rows from the line buffers plus the incoming pixel.
    // Past the end of the image there is no incoming row, so it is zero.
    always_comb begin
        col_new[0] = row2_rd;
        col_new[1] = row1_rd;
        col_new[2] = (state == FLUSH) ? '0 : in_pixel;
    end

    pw_line_buffer #(.DEPTH(WIDTH), .DW(PW)) u_row1 (
        .clk(clk), .we(shift), .addr(ix), .wdata(col_new[2]), .rdata(row1_rd)
    );
    pw_line_buffer #(.DEPTH(WIDTH), .DW(PW)) u_row2 (
        .clk(clk), .we(shift), .addr(ix), .wdata(row1_rd), .rdata(row2_rd)
    );

    // Raw taps may hold stale line-buffer data or columns from the wrong row;
    // every such tap lies outside the image for the centre (cx,cy), so the
    // border handling below covers them.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win[r*3 + 0] = hist0[r];
            win[r*3 + 1] = hist1[r];
            win[r*3 + 2] = col_new[r];
        end
`ifdef PIXEL_WINDOW_REPLICATE_EN
        // Columns first, then rows, so corners take the centre pixel's value.
        for (int r = 0; r < 3; r++) begin
            if (cx == '0)    win[r*3 + 0] = win[r*3 + 1];
            if (cx == X_MAX) win[r*3 + 2] = win[r*3 + 1];
        end
        for (int c = 0; c < 3; c++) begin
            if (cy == '0)    win[c]     = win[3 + c];
            if (cy == Y_MAX) win[6 + c] = win[3 + c];
        end
`else
        for (int r = 0; r < 3; r++) begin
            if (cx == '0)    win[r*3 + 0] = '0;
            if (cx == X_MAX) win[r*3 + 2] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            if (cy == '0)    win[c]     = '0;
            if (cy == Y_MAX) win[6 + c] = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            hist0 <= hist1;
            hist1 <= col_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            ix        <= '0;
            iy        <= '0;
            cx        <= '0;
            cy        <= '0;
            out_valid <= 1'b0;
            out_win   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH && state_nxt == FILL) begin
                ix <= '0;
                iy <= '0;
            end else if (shift) begin
                if (ix == X_MAX) begin
                    ix <= '0;
                    iy <= (iy == Y_MAX) ? '0 : iy + 1'b1;
                end else begin
                    ix <= ix + 1'b1;
                end
            end
            if (load) begin
                if (cx == X_MAX) begin
                    cx <= '0;
                    cy <= (cy == Y_MAX) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
                out_valid <= 1'b1;
                out_win   <= win;
                out_x     <= cx;
                out_y     <= cy;
                out_last  <= (cx == X_MAX) && (cy == Y_MAX);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_window_3x3.sv
module tb_pixel_window_3x3;
    localparam int AW = 4,  AH = 3;
    localparam int BW = 13, BH = 7;

`ifdef PIXEL_WINDOW_REPLICATE_EN
    localparam logic [71:0] FIRST_W = {8'd5,8'd4,8'd4,8'd1,8'd0,8'd0,8'd1,8'd0,8'd0};
    localparam logic [71:0] LAST_W  = {8'd11,8'd11,8'd10,8'd11,8'd11,8'd10,8'd7,8'd7,8'd6};
`else
    localparam logic [71:0] FIRST_W = {8'd5,8'd4,8'd0,8'd1,8'd0,8'd0,8'd0,8'd0,8'd0};
    localparam logic [71:0] LAST_W  = {8'd0,8'd0,8'd0,8'd0,8'd11,8'd10,8'd0,8'd7,8'd6};
`endif
    localparam logic [71:0] MID_W = {8'd10,8'd9,8'd8,8'd6,8'd5,8'd4,8'd2,8'd1,8'd0};

    typedef struct {
        logic [71:0] win;
        int          x;
        int          y;
        bit          last;
    } exp_t;

    logic clk = 0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [7:0]  a_in_pixel;
    logic [71:0] a_out_win;
    logic [1:0]  a_out_x, a_out_y;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0]  b_in_pixel;
    logic [71:0] b_out_win;
    logic [3:0]  b_out_x;
    logic [2:0]  b_out_y;

    pixel_window_3x3 #(.WIDTH(AW), .HEIGHT(AH), .PW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pixel(a_in_pixel), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_win(a_out_win), .out_x(a_out_x), .out_y(a_out_y), .out_last(a_out_last)
    );
    pixel_window_3x3 #(.WIDTH(BW), .HEIGHT(BH), .PW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pixel(b_in_pixel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_win(b_out_win), .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last)
    );

    int checks = 0, passed = 0;
    int cyc = 0;
    exp_t qa[$], qb[$];
    logic [7:0] fa[$], fb[$];
    int a_cnt = 0, a_lastcnt = 0, b_cnt = 0, b_lastcnt = 0;
    int a_stall = 0, a_stallcyc = 0;
    bit a_rrand = 0, b_rrand = 0, a_dir = 0, in_reset = 0;
    int a_first_cyc = -1, a_acc5 = -2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: tap (x,y) of a frame stored in raster order.
    function automatic logic [7:0] tap(input int w, input int h, input int x, input int y,
                                       input logic [7:0] f[$]);
`ifdef PIXEL_WINDOW_REPLICATE_EN
        if (x < 0) x = 0;
        if (x > w-1) x = w-1;
        if (y < 0) y = 0;
        if (y > h-1) y = h-1;
`else
        if (x < 0 || x >= w || y < 0 || y >= h) return 8'd0;
`endif
        return f[y*w + x];
    endfunction

    function automatic logic [71:0] ref_win(input int w, input int h, input int x, input int y,
                                            input logic [7:0] f[$]);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = tap(w, h, x + k%3 - 1, y + k/3 - 1, f);
        return r;
    endfunction

    // After pixel n is known, every window whose neighbourhood is complete is queued.
    function automatic void push_exp(input bit b, input int w, input int h, input int n);
        int c0, c1;
        exp_t e;
        if (n < w + 1) return;
        c0 = n - (w + 1);
        c1 = (n == w*h - 1) ? w*h - 1 : c0;
        for (int c = c0; c <= c1; c++) begin
            e.x = c % w;
            e.y = c / w;
            e.last = (c == w*h - 1);
            e.win = ref_win(w, h, e.x, e.y, b ? fb : fa);
            if (b) qb.push_back(e); else qa.push_back(e);
        end
    endfunction

    task automatic set_in(input bit b, input bit v, input logic [7:0] p);
        if (b) begin b_in_valid = v; b_in_pixel = p; end
        else   begin a_in_valid = v; a_in_pixel = p; end
    endtask

    task automatic drive_frame(input bit b, input int w, input int h, input bit rnd,
                               input int npix, input int stall_at);
        int n, guard;
        logic [7:0] p;
        bit v;
        n = 0; guard = 0;
        if (b) fb.delete(); else fa.delete();
        @(posedge clk); #1;
        while (n < npix && guard < 20000) begin
            p = rnd ? 8'($urandom) : 8'(n);
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            set_in(b, v, p);
            @(negedge clk);
            if (v && (b ? b_in_ready : a_in_ready)) begin
                if (b) fb.push_back(p); else fa.push_back(p);
                push_exp(b, w, h, n);
                if (!b && n == 5) a_acc5 = cyc + 1;
                if (!b && n == stall_at) a_stall = 3;
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        set_in(b, 1'b0, 8'd0);
        if (n < npix) check("drive_timeout", 128'(n), 128'(npix));
    endtask

    task automatic drain(input bit b, input int nwin);
        int g;
        g = 0;
        while ((b ? qb.size() : qa.size()) != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 5000) check("drain_timeout", 128'(b ? qb.size() : qa.size()), 128'(0));
        repeat (3) @(negedge clk);
        check(b ? "b_idle_valid" : "a_idle_valid", 128'(b ? b_out_valid : a_out_valid), 128'(0));
        check(b ? "b_win_count" : "a_win_count", 128'(b ? b_cnt : a_cnt), 128'(nwin));
        check(b ? "b_last_count" : "a_last_count", 128'(b ? b_lastcnt : a_lastcnt),
              128'(nwin / (b ? BW*BH : AW*AH)));
        if (b) begin b_cnt = 0; b_lastcnt = 0; end else begin a_cnt = 0; a_lastcnt = 0; end
    endtask

    initial begin
        a_out_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (a_stall > 0) begin a_out_ready = 0; a_stall--; end
            else a_out_ready = a_rrand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        b_out_ready = 1;
        forever begin
            @(posedge clk); #1;
            b_out_ready = b_rrand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor for the 4x3 instance: pops the scoreboard on every transfer.
    initial begin
        exp_t e;
        bit prev_stall;
        logic [71:0] prev_win;
        prev_stall = 0;
        prev_win = '0;
        forever begin
            @(negedge clk);
            if (in_reset || !rst_n) begin
                prev_stall = 0;
            end else begin
                if (a_out_valid && a_first_cyc < 0) a_first_cyc = cyc;
                if (prev_stall) check("a_stall_hold", {a_out_valid, a_out_win}, {1'b1, prev_win});
                if (a_out_valid && !a_out_ready) begin
                    check("a_in_ready_stalled", 128'(a_in_ready), 128'(0));
                    a_stallcyc++;
                end
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) check("a_unexpected_window", 128'(a_out_win), 128'(0));
                    else begin
                        e = qa.pop_front();
                        check("a_win", 128'(a_out_win), 128'(e.win));
                        check("a_xy_last", {16'(a_out_x), 16'(a_out_y), a_out_last},
                              {16'(e.x), 16'(e.y), e.last});
                        if (a_dir && e.x == 0 && e.y == 0) check("a_first_const", 128'(a_out_win), 128'(FIRST_W));
                        if (a_dir && e.x == 1 && e.y == 1) check("a_mid_const", 128'(a_out_win), 128'(MID_W));
                        if (a_dir && e.last) check("a_last_const", 128'(a_out_win), 128'(LAST_W));
                        a_cnt++;
                        if (a_out_last) a_lastcnt++;
                    end
                end
                prev_stall = a_out_valid && !a_out_ready;
                prev_win = a_out_win;
            end
        end
    end

    // Monitor for the 13x7 instance.
    initial begin
        exp_t e;
        bit prev_stall;
        logic [71:0] prev_win;
        prev_stall = 0;
        prev_win = '0;
        forever begin
            @(negedge clk);
            if (in_reset || !rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) check("b_stall_hold", {b_out_valid, b_out_win}, {1'b1, prev_win});
                if (b_out_valid && !b_out_ready) check("b_in_ready_stalled", 128'(b_in_ready), 128'(0));
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) check("b_unexpected_window", 128'(b_out_win), 128'(0));
                    else begin
                        e = qb.pop_front();
                        check("b_win", 128'(b_out_win), 128'(e.win));
                        check("b_xy_last", {16'(b_out_x), 16'(b_out_y), b_out_last},
                              {16'(e.x), 16'(e.y), e.last});
                        b_cnt++;
                        if (b_out_last) b_lastcnt++;
                    end
                end
                prev_stall = b_out_valid && !b_out_ready;
                prev_win = b_out_win;
            end
        end
    end

    initial begin
        rst_n = 1;
        set_in(1'b0, 1'b0, 8'd0);
        set_in(1'b1, 1'b0, 8'd0);
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_a_outputs", {a_out_valid, a_out_last, a_out_x, a_out_y, a_out_win}, '0);
        check("rst_b_outputs", {b_out_valid, b_out_last, b_out_x, b_out_y, b_out_win}, '0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_a_in_ready", 128'(a_in_ready), 128'(1));

        // 4x3 ramp, no gaps, always ready
        a_dir = 1;
        drive_frame(1'b0, AW, AH, 1'b0, AW*AH, -1);
        drain(1'b0, AW*AH);
        check("a_first_valid_cycle", 128'(a_first_cyc), 128'(a_acc5));
        a_dir = 0;

        // Same ramp with a three-cycle output stall in the middle of RUN
        a_stallcyc = 0;
        drive_frame(1'b0, AW, AH, 1'b0, AW*AH, 7);
        drain(1'b0, AW*AH);
        check("a_stall_cycles", 128'(a_stallcyc), 128'(3));

        // Random pixels and handshakes on the small frame
        a_rrand = 1;
        for (int f = 0; f < 3; f++) drive_frame(1'b0, AW, AH, 1'b1, AW*AH, -1);
        drain(1'b0, 3*AW*AH);
        a_rrand = 0;

        // Two back-to-back random frames on the larger frame
        b_rrand = 1;
        drive_frame(1'b1, BW, BH, 1'b1, BW*BH, -1);
        drive_frame(1'b1, BW, BH, 1'b1, BW*BH, -1);
        drain(1'b1, 2*BW*BH);

        // Reset in the middle of a frame
        drive_frame(1'b1, BW, BH, 1'b1, 50, -1);
        #2;
        in_reset = 1;
        rst_n = 0;
        #1;
        check("midrst_b_outputs", {b_out_valid, b_out_last, b_out_x, b_out_y, b_out_win}, '0);
        qb.delete();
        b_cnt = 0;
        b_lastcnt = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        in_reset = 0;
        check("midrst_b_in_ready", 128'(b_in_ready), 128'(1));
        drive_frame(1'b1, BW, BH, 1'b1, BW*BH, -1);
        drain(1'b1, BW*BH);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pixel_window_3x3.md
Name: pixel_window_3x3

Overview:
- Streaming front end for the border-detection datapath.
- Accepts a raster-order pixel stream (one 8-bit grey pixel per handshake) and builds a 3x3 neighbourhood around every pixel using two on-chip line buffers.
- Emits exactly WIDTH*HEIGHT windows per frame, in raster order of their centre pixel. The edge-detection kernel consumes these windows, replacing whole-frame array loading with a pipelined stream.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame; WIDTH*HEIGHT = 76800 at default.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  block can accept a pixel this cycle
- in_pixel  input  PIX_W  pixel value, raster order
- out_valid  output  1  window valid
- out_ready  input  1  downstream accepts the window
- out_win  output  9*PIX_W  window; element k at bits [k*PIX_W +: PIX_W]; k=0 top-left, k=4 centre, k=8 bottom-right, row-major
- out_x  output  $clog2(WIDTH)  centre column
- out_y  output  $clog2(HEIGHT)  centre row
- out_last  output  1  asserted with the final window of the frame (centre WIDTH-1, HEIGHT-1)

Behaviour:
- Reset (async assert, sync release):
  - state=FILL; input and output counters=0.
  - out_valid=0, out_win=0, out_x=0, out_y=0, out_last=0.
  - in_ready=1 after release.
  - Line-buffer contents are not cleared; they are masked by position logic.
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
- FILL state:
  - Accepts the first WIDTH+1 pixels; no windows are emitted.
  - in_ready=1.
  - Moves to RUN on the edge accepting pixel index WIDTH (coordinate (0,1)).
- RUN state:
  - Each accepted pixel at index n produces the window centred at index n-(WIDTH+1).
  - The window is registered: out_valid rises the cycle after the accepting edge.
  - in_ready = !out_valid || out_ready, so one window is buffered and there is no combinational path from in_valid to out_valid.
  - Moves to FLUSH on the edge accepting pixel index WIDTH*HEIGHT-1.
- FLUSH state:
  - in_ready=0.
  - Emits the remaining WIDTH+1 windows using zero/padded data for the missing bottom row.
  - One window per cycle whenever the output register is free.
  - After the transfer carrying out_last, returns to FILL for the next frame.
- Stall rule: out_win, out_x, out_y and out_last hold stable while out_valid && !out_ready.
- Padding (macro off): taps outside the image read as 0. This applies to:
  - the row above y=0 and below y=HEIGHT-1;
  - the column left of x=0 and right of x=WIDTH-1.
- Coordinates: out_x wraps WIDTH-1 -> 0 and increments out_y. Counters never exceed WIDTH-1 or HEIGHT-1.
- Simultaneous input accept and output transfer in RUN: both occur. The new window loads in the same cycle, giving sustained one window per clock.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is pixel (0,0).

Optional Feature:
- Macro PIXEL_WINDOW_REPLICATE_EN.
- When defined: out-of-image taps take the nearest in-image pixel (edge replication). For example, the top-left tap at (0,0) equals pixel (0,0).
- When undefined: zero padding as above.
- Handshake, latency and window count are identical in both builds.

Decomposition:
- Package border_pkg:
  - IMG_W=320, IMG_H=240, IMG_SIZE=76800, PIX_W=8;
  - typedef pixel_t (logic [PIX_W-1:0]);
  - typedef enum win_state_t {FILL, RUN, FLUSH}.
- Sub-module pw_line_buffer:
  - depth WIDTH, width PIX_W;
  - single read/write address, read-before-write; an inferable RAM.
  - It is instantiated twice, chained, to provide rows y-1 and y-2.
- A 3x3 shift-register tap array and the padding muxes stay in the top module.

Test Plan:
- WIDTH=4, HEIGHT=3, pixel n=n, out_ready=1, stream without gaps:
  - out_valid first rises the cycle after pixel 5 is accepted;
  - first window = {0,0,0,0,0,1,0,4,5}, out_x=0, out_y=0.
- Same stream: window centred at (1,1) = {0,1,2,4,5,6,8,9,10}; exactly 12 windows; out_last only on the window with out_x=3, out_y=2, which equals {6,7,0,10,11,0,0,0,0}.
- Same stream, with out_ready held 0 for 3 cycles mid-RUN:
  - in_ready=0 while stalled;
  - out_win stable;
  - no window lost or duplicated; count is still 12.
- Default 320x240, random pixels, random in_valid and out_ready:
  - all 76800 windows match a reference 3x3 zero-padded model;
  - second back-to-back frame also matches.
- Assert rst_n low after 50 pixels: out_valid=0 immediately (async). After release, a full frame produces correct windows starting at (0,0).
- PIXEL_WINDOW_REPLICATE_EN build, 4x3 stream: first window = {0,0,1,0,0,1,4,4,5}.
